// File: rtl/fifo_pkg.sv
// Shared types and defaults for the parametrised sync FIFO.
// FIFO_FWFT_EN selects first-word-fall-through in fifo_sync_param.
package fifo_pkg;

  localparam int FIFO_DEF_WIDTH = 8;
  localparam int FIFO_DEF_DEPTH = 16;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WR,
    OP_RD,
    OP_WRRD
  } fifo_op_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x WIDTH register array for the sync FIFO.
// One synchronous write port, one asynchronous read address.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_DEF_WIDTH,
  parameter int DEPTH = FIFO_DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // storage is never reset; the owner tracks what is valid
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, thresholds and error pulses.
// Define FIFO_FWFT_EN for first-word-fall-through output.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_DEF_WIDTH,
  parameter int DEPTH    = FIFO_DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] d_in,
  input  logic             rd,
  output logic [WIDTH-1:0] d_out,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_C    = (AW + 1)'(AE_LEVEL);
  localparam logic [AW:0] ONE     = (AW + 1)'(1);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("fifo_sync_param: DEPTH must be a power of 2 >= 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("fifo_sync_param: AE_LEVEL must be below AF_LEVEL");
  end

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      cnt;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] rdata;
  fifo_op_e         op;

  assign empty        = (cnt == '0);
  assign full         = (cnt == DEPTH_C);
  assign almost_full  = (cnt >= AF_C);
  assign almost_empty = (cnt <= AE_C);
  assign count        = cnt;

  // a pop frees the slot a same-cycle push needs when full
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  // classify the accepted operations of this cycle
  always_comb begin
    op = OP_IDLE;
    unique case (1'b1)
      (wr_acc & rd_acc):  op = OP_WRRD;
      (wr_acc & ~rd_acc): op = OP_WR;
      (~wr_acc & rd_acc): op = OP_RD;
      default:            op = OP_IDLE;
    endcase
  end

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk  (clk),
    .we   (wr_acc & ~clr),
    .waddr(wr_ptr[AW-1:0]),
    .wdata(d_in),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );

  // pointers and occupancy; clear wins over any request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE;
      if (rd_acc) rd_ptr <= rd_ptr + ONE;
      unique case (op)
        OP_WR:   cnt <= cnt + ONE;
        OP_RD:   cnt <= cnt - ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // one-cycle pulses for rejected requests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ~clr & wr & ~wr_acc;
      underflow <= ~clr & rd & empty;
    end
  end

`ifdef FIFO_FWFT_EN
  assign d_out    = empty ? '0 : rdata;
  assign rd_valid = ~empty;
`else
  logic [WIDTH-1:0] dout_q;
  logic             rv_q;

  // registered read data, held between pops
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      rv_q   <= 1'b0;
    end else if (clr) begin
      rv_q   <= 1'b0;
    end else begin
      rv_q <= rd_acc;
      if (rd_acc) dout_q <= rdata;
    end
  end

  assign d_out    = dout_q;
  assign rd_valid = rv_q;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised bench for fifo_sync_param against a queue model.
// Build with FIFO_FWFT_EN defined to exercise fall-through mode.
module tb_fifo_sync_param;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       wr;
  logic       rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int vec  = 0;
  int errs = 0;

  bit [7:0] mq[$];
  logic [7:0] m_dout;
  bit m_rv;
  bit m_ov;
  bit m_un;

  fifo_sync_param #(
    .WIDTH(8),
    .DEPTH(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clr         (clr),
    .wr          (wr),
    .d_in        (d_in),
    .rd          (rd),
    .d_out       (d_out),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    m_dout = 8'h00;
    m_rv   = 1'b0;
    m_ov   = 1'b0;
    m_un   = 1'b0;
  endtask

  task automatic step(input bit w, input bit r, input bit c,
                      input logic [7:0] d);
    int n;
    bit ra;
    bit wa;
    wr = w;
    rd = r;
    clr = c;
    d_in = d;
    @(posedge clk);
    n  = mq.size();
    ra = r && (n > 0);
    wa = w && ((n < D) || ra);
    if (c) begin
      mq.delete();
      m_rv = 1'b0;
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      m_ov = w && !wa;
      m_un = r && (n == 0);
      m_rv = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(d);
    end
`ifdef FIFO_FWFT_EN
    m_dout = (mq.size() > 0) ? mq[0] : 8'h00;
    m_rv   = (mq.size() > 0);
`endif
    #1;
    wr  = 1'b0;
    rd  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr   = 1'($urandom);
      rd   = 1'($urandom);
      d_in = 8'($urandom);
      @(posedge clk);
      #1;
      vec++;
      if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
        $display("FAIL reset_flags count=%0d empty=%b full=%b exp 0/1/0",
                 count, empty, full);
        errs++;
      end
      vec++;
      if (d_out !== 8'h00 || rd_valid !== 1'b0) begin
        $display("FAIL reset_dout d_out=%h rv=%b exp 00/0", d_out, rd_valid);
        errs++;
      end
      vec++;
      if (overflow !== 1'b0 || underflow !== 1'b0 ||
          almost_empty !== 1'b1 || almost_full !== 1'b0) begin
        $display("FAIL reset_pulses ov=%b un=%b ae=%b af=%b exp 0/0/1/0",
                 overflow, underflow, almost_empty, almost_full);
        errs++;
      end
    end
    wr = 1'b0;
    rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= D; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(i));
      vec++;
      if (count !== 5'(i) || full !== (i == D) ||
          almost_full !== (i >= 14) || almost_empty !== (i <= 2)) begin
        $display("FAIL fill i=%0d count=%0d full=%b af=%b ae=%b",
                 i, count, full, almost_full, almost_empty);
        errs++;
      end
    end
    for (int k = 1; k <= D; k++) begin
`ifdef FIFO_FWFT_EN
      vec++;
      if (d_out !== 8'(k) || rd_valid !== 1'b1) begin
        $display("FAIL drain_fwft k=%0d d_out=%h rv=%b exp %h/1",
                 k, d_out, rd_valid, 8'(k));
        errs++;
      end
`endif
      step(1'b0, 1'b1, 1'b0, 8'h00);
`ifndef FIFO_FWFT_EN
      vec++;
      if (d_out !== 8'(k) || rd_valid !== 1'b1) begin
        $display("FAIL drain k=%0d d_out=%h rv=%b exp %h/1",
                 k, d_out, rd_valid, 8'(k));
        errs++;
      end
`endif
      vec++;
      if (count !== 5'(D - k)) begin
        $display("FAIL drain_count k=%0d count=%0d exp %0d", k, count, D - k);
        errs++;
      end
    end
    vec++;
    if (empty !== 1'b1) begin
      $display("FAIL drain_empty empty=%b exp 1", empty);
      errs++;
    end
  endtask

  task automatic test_over_under();
    logic [7:0] hold;
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    vec++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      $display("FAIL overflow ov=%b count=%0d full=%b exp 1/16/1",
               overflow, count, full);
      errs++;
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    vec++;
    if (overflow !== 1'b0) begin
      $display("FAIL overflow_clear ov=%b exp 0", overflow);
      errs++;
    end
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      vec++;
      if (d_out !== m_dout || count !== 5'(mq.size())) begin
        $display("FAIL ovf_drain i=%0d d_out=%h count=%0d exp %h/%0d",
                 i, d_out, count, m_dout, mq.size());
        errs++;
      end
    end
    hold = d_out;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    vec++;
    if (underflow !== 1'b1 || d_out !== hold || count !== 5'd0) begin
      $display("FAIL underflow un=%b d_out=%h count=%0d exp 1/%h/0",
               underflow, d_out, count, hold);
      errs++;
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    vec++;
    if (underflow !== 1'b0) begin
      $display("FAIL underflow_clear un=%b exp 0", underflow);
      errs++;
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h11 + i));
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    vec++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL full_wrrd count=%0d full=%b ov=%b exp 16/1/0",
               count, full, overflow);
      errs++;
    end
`ifndef FIFO_FWFT_EN
    vec++;
    if (d_out !== 8'h11 || rd_valid !== 1'b1) begin
      $display("FAIL full_wrrd_head d_out=%h rv=%b exp 11/1", d_out, rd_valid);
      errs++;
    end
`endif
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      vec++;
      if (d_out !== m_dout) begin
        $display("FAIL wrrd_drain i=%0d d_out=%h exp %h", i, d_out, m_dout);
        errs++;
      end
    end
`ifndef FIFO_FWFT_EN
    vec++;
    if (d_out !== 8'hAA) begin
      $display("FAIL tail_aa d_out=%h exp aa", d_out);
      errs++;
    end
`endif
    step(1'b1, 1'b1, 1'b0, 8'h3C);
    vec++;
    if (count !== 5'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
      $display("FAIL empty_wrrd count=%0d un=%b empty=%b exp 1/1/0",
               count, underflow, empty);
      errs++;
    end
  endtask

  task automatic test_wrap_clear();
    bit w;
    bit r;
    bit c;
    for (int i = 0; i < 40; i++) begin
      w = (i < 20) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = (i < 20) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      c = (i == 20);
      step(w, r, c, 8'($urandom));
      vec++;
      if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) ||
          full !== (mq.size() == D)) begin
        $display("FAIL mix_flags i=%0d count=%0d empty=%b full=%b exp %0d",
                 i, count, empty, full, mq.size());
        errs++;
      end
      vec++;
      if (d_out !== m_dout || rd_valid !== m_rv ||
          overflow !== m_ov || underflow !== m_un) begin
        $display("FAIL mix_data i=%0d d_out=%h rv=%b ov=%b un=%b exp %h/%b/%b/%b",
                 i, d_out, rd_valid, overflow, underflow,
                 m_dout, m_rv, m_ov, m_un);
        errs++;
      end
      if (c) begin
        vec++;
        if (count !== 5'd0 || empty !== 1'b1) begin
          $display("FAIL clear count=%0d empty=%b exp 0/1", count, empty);
          errs++;
        end
      end
    end
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    wr   = 1'b1;
    d_in = 8'h77;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vec++;
    if (count !== 5'd0 || empty !== 1'b1 || d_out !== 8'h00) begin
      $display("FAIL rst_mid count=%0d empty=%b d_out=%h exp 0/1/00",
               count, empty, d_out);
      errs++;
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
    vec++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      $display("FAIL rst_hold count=%0d empty=%b exp 0/1", count, empty);
      errs++;
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    vec++;
    if (count !== 5'd0 || rd_valid !== 1'b0) begin
      $display("FAIL rst_after count=%0d rv=%b exp 0/0", count, rd_valid);
      errs++;
    end
  endtask

  task automatic test_first_word();
    step(1'b1, 1'b0, 1'b0, 8'h55);
`ifdef FIFO_FWFT_EN
    vec++;
    if (d_out !== 8'h55 || rd_valid !== 1'b1) begin
      $display("FAIL fwft_head d_out=%h rv=%b exp 55/1", d_out, rd_valid);
      errs++;
    end
`else
    vec++;
    if (rd_valid !== 1'b0 || d_out !== m_dout) begin
      $display("FAIL std_nopop d_out=%h rv=%b exp %h/0", d_out, rd_valid, m_dout);
      errs++;
    end
`endif
    step(1'b0, 1'b1, 1'b0, 8'h00);
    vec++;
    if (empty !== 1'b1 || d_out !== m_dout || rd_valid !== m_rv) begin
      $display("FAIL first_pop empty=%b d_out=%h rv=%b exp 1/%h/%b",
               empty, d_out, rd_valid, m_dout, m_rv);
      errs++;
    end
  endtask

  initial begin
    rst  = 1'b0;
    clr  = 1'b0;
    wr   = 1'b0;
    rd   = 1'b0;
    d_in = 8'h00;
    model_reset();
    test_reset();
    test_fill_drain();
    test_over_under();
    test_simultaneous();
    test_wrap_clear();
    test_first_word();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
